seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, registered successor to the team's 24-bit combinational ALU.
- Same 3-bit opcode map, with these additions:
  - configurable data width;
  - valid/ready handshakes on input and output;
  - iterative multi-cycle multiply and divide;
  - status flags.
- Sits between the register file/operand latch and the writeback stage of the CPU datapath; one operation in flight at a time.

Parameters:
- WIDTH, 24: operand and result width in bits, ≥ 4.
- SH_W, clog2(WIDTH): internal shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- select  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 MUL, 101 DIV, 110 SHL, 111 SAR
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- c  out  WIDTH  result
- flag_z  out  1  c == 0
- flag_n  out  1  c[WIDTH-1]
- flag_c  out  1  ADD carry-out / SUB borrow (a < b unsigned); 0 for other ops
- flag_v  out  1  ADD/SUB signed overflow; MUL: nonzero high product half; 0 otherwise
- flag_dz  out  1  DIV with b == 0; 0 otherwise

Behaviour:
- Reset (async, rst=1):
  - state ← IDLE;
  - c, all flags, out_valid ← 0;
  - in_ready ← 1 once the state is IDLE.
  - Any operation in progress is discarded; no output is produced for it.
- States: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- IDLE: on in_valid=1, latch a, b, select.
  - Ops 000, 001, 010, 011, 110, 111 → compute and register c/flags, go to DONE. out_valid is high 1 cycle after the accept edge.
  - Ops 100, 101 → load iteration counter = WIDTH, go to BUSY.
- BUSY: one iteration per cycle; the counter decrements each cycle.
  - On the edge where the counter reaches 0, write c/flags and go to DONE. out_valid is high exactly WIDTH cycles after the accept edge.
  - in_valid is ignored while BUSY.
- DONE: c/flags are held stable while out_ready=0.
  - out_ready=1 → IDLE on that edge; outputs keep their value (not cleared).
  - No new accept in the same cycle as the DONE→IDLE transition. Maximum throughput is one single-cycle op every 2 cycles.
- Arithmetic, all unsigned except flags and SAR:
  - ADD/SUB: c = (a ± b) mod 2^WIDTH.
  - MUL: shift-add over WIDTH iterations; c = low WIDTH bits of the 2·WIDTH product; flag_v = |high half.
  - DIV: restoring divide over WIDTH iterations; c = floor(a/b).
  - b == 0: c = all ones, flag_dz = 1, still WIDTH cycles of latency.
  - SHL: c = a << b. If b ≥ WIDTH (any upper bit set), c = 0.
  - SAR: arithmetic right shift of a as signed. If b ≥ WIDTH, c = replicated a[WIDTH-1].
- flag_z and flag_n are derived from the final c for every op.
- Operand inputs may change after acceptance without affecting the result.
- A reset asserted in any state, including mid-BUSY or DONE with out_ready=0, behaves as reset above.

Test Plan (WIDTH=24):
- ADD: a=0xFFFFFF, b=0x000001, select=010 → 1 cycle later out_valid=1, c=0x000000, flag_z=1, flag_c=1, flag_v=0; with out_ready=1, in_ready returns next cycle.
- SUB/flags: a=0x7FFFFF, b=0xFFFFFF, select=011 → c=0x800000, flag_n=1, flag_v=1, flag_c=1.
- MUL: a=0x001000, b=0x001000, select=100 → in_ready low for 24 cycles; out_valid exactly 24 cycles after accept; c=0x000000, flag_z=1, flag_v=1.
- DIV: a=100, b=7 → c=14 after 24 cycles. Then a=5, b=0 → c=0xFFFFFF, flag_dz=1.
- Shifts: SHL a=0x000001, b=5 → c=0x000020. SAR a=0x800000, b=4 → c=0xF80000. SAR a=0x800000, b=30 → c=0xFFFFFF. SHL b=24 → c=0.
- Backpressure/reset:
  - hold out_ready=0 for 10 cycles after ADD → c stable, in_valid ignored;
  - assert rst at BUSY cycle 12 of a MUL → out_valid=0, c=0 immediately, in_ready=1 after release, no stale result appears.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked ALU with iterative shift-add multiply, restoring divide and flags.
// One operation in flight; single-cycle ops finish on the accept edge, MUL/DIV after WIDTH busy cycles.
module seq_alu #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SAR = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic              accept, finish, iter_op;
  logic [CNT_W-1:0]  cnt;
  logic              op_mul;
  logic [WIDTH-1:0]  opa, opb, hi, lo;
  logic [WIDTH-1:0]  hi_nxt, lo_nxt;
  logic [WIDTH:0]    mul_sum, div_sh;
  logic              div_ge;
  logic [WIDTH:0]    sum, diff;
  logic [WIDTH-1:0]  sc_res;
  logic              sc_c, sc_v;

  assign iter_op = (select == OP_MUL) || (select == OP_DIV);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = iter_op ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle operations, evaluated straight from the live operands at accept
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (select)
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: sc_res = (b >= WIDTH'(WIDTH)) ? '0 : (a << b[SH_W-1:0]);
      OP_SAR: sc_res = (b >= WIDTH'(WIDTH)) ? {WIDTH{a[WIDTH-1]}}
                                            : WIDTH'($signed(a) >>> b[SH_W-1:0]);
      default: ;
    endcase
  end

  // One iteration: hi/lo hold {product high, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
    div_sh  = {hi, lo[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, opb});
    if (op_mul) begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_nxt = div_ge ? (div_sh[WIDTH-1:0] - opb) : div_sh[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_mul <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      cnt    <= CNT_W'(WIDTH);
      op_mul <= (select == OP_MUL);
      opa    <= a;
      opb    <= b;
      hi     <= '0;
      lo     <= (select == OP_MUL) ? b : a;
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
      hi  <= hi_nxt;
      lo  <= lo_nxt;
    end
  end

  // Registered handshake, result and flags; result is held through DONE and after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_dz   <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept && !iter_op) begin
        c       <= sc_res;
        flag_z  <= (sc_res == '0);
        flag_n  <= sc_res[WIDTH-1];
        flag_c  <= sc_c;
        flag_v  <= sc_v;
        flag_dz <= 1'b0;
      end else if (finish) begin
        c       <= lo_nxt;
        flag_z  <= (lo_nxt == '0);
        flag_n  <= lo_nxt[WIDTH-1];
        flag_c  <= 1'b0;
        flag_v  <= op_mul && (hi_nxt != '0);
        flag_dz <= !op_mul && (opb == '0);
      end
    end
  end

endmodule
